// File: rtl/bn_pkg.sv
// Shared types and fixed-point helpers for the batch-norm backward datapath.
package bn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } bn_state_t;

    typedef enum logic [1:0] {
        PH_ACC,
        PH_SCALE,
        PH_DX
    } bn_phase_t;

    function automatic logic [31:0] recip(input int n, input int fl);
        if (n <= 0) return '0;
        return (32'd1 << fl) / 32'(n);
    endfunction

    function automatic logic signed [63:0] sat_q(input logic signed [63:0] v, input int il, input int fl);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (il + fl - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (il + fl - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Signed Q(IL.FL) multiply: full-width product, arithmetic shift by FL, saturate to IL+FL bits.
module fx_mul_sat
    import bn_pkg::*;
#(
    parameter int IL = 4,
    parameter int FL = 16
) (
    input  logic signed [IL+FL-1:0] i_a,
    input  logic signed [IL+FL-1:0] i_b,
    output logic signed [IL+FL-1:0] o_p
);
    localparam int W = IL + FL;

    logic signed [2*W-1:0] w_a;
    logic signed [2*W-1:0] w_b;
    logic signed [2*W-1:0] w_prod;
    logic signed [63:0]    w_ext;

    assign w_a    = {{W{i_a[W-1]}}, i_a};
    assign w_b    = {{W{i_b[W-1]}}, i_b};
    assign w_prod = w_a * w_b;
    assign w_ext  = {{(64-2*W){w_prod[2*W-1]}}, w_prod};
    assign o_p    = W'(sat_q(w_ext >>> FL, IL, FL));

endmodule

// File: rtl/batchnorm_backward.sv
// Batch-norm backward pass: accumulate dbeta/dgamma, form the means, then stream dx one element per cycle.
module batchnorm_backward
    import bn_pkg::*;
#(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int size  = 16,
    parameter int width = $clog2(size)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [size*(IL+FL)-1:0] dout,
    input  logic [size*(IL+FL)-1:0] xhat,
    input  logic signed [IL+FL-1:0] gamma,
    input  logic signed [IL+FL-1:0] inv_std,
    input  logic [4:0]              num,
    input  logic                    input_ready,
    input  logic                    output_taken,
    output logic [size*(IL+FL)-1:0] dx,
    output logic signed [IL+FL-1:0] dgamma,
    output logic signed [IL+FL-1:0] dbeta,
    output logic [1:0]              state,
    output logic                    done
);
    localparam int W  = IL + FL;
    localparam int AW = W + width + 1;
    localparam logic [width:0] NMAX = (width+1)'(size);

    bn_state_t        r_state, w_state_nx;
    bn_phase_t        r_phase, w_phase_nx;
    logic [width-1:0] r_idx, w_idx_nx;
    logic [width:0]   r_n, w_n_in;
    logic             w_last;

    logic signed [W-1:0]  r_dout [size];
    logic signed [W-1:0]  r_xhat [size];
    logic signed [W-1:0]  r_dx   [size];
    logic signed [W-1:0]  r_gamma, r_inv_std, r_mb, r_mg, r_scale, r_dbeta, r_dgamma;
    logic signed [AW-1:0] r_acc_b, r_acc_g;

    logic signed [W-1:0] w_dout_cur, w_xhat_cur, w_prod_acc, w_xm, w_sc_a, w_sc_b, w_sc_p, w_diff;
    logic signed [63:0]  w_acc_b64, w_acc_g64, w_recip64, w_dout64, w_inner64;

    assign w_n_in     = (int'(num) > size) ? NMAX : (width+1)'(num);
    assign w_last     = ({1'b0, r_idx} == (r_n - 1'b1));
    assign w_dout_cur = r_dout[r_idx];
    assign w_xhat_cur = r_xhat[r_idx];

    // One multiplier forms gamma*inv_std during SCALE and the final dx product during DX.
    assign w_sc_a = (r_phase == PH_SCALE) ? r_gamma   : r_scale;
    assign w_sc_b = (r_phase == PH_SCALE) ? r_inv_std : w_diff;

    fx_mul_sat #(.IL(IL), .FL(FL)) u_acc (.i_a(w_dout_cur), .i_b(w_xhat_cur), .o_p(w_prod_acc));
    fx_mul_sat #(.IL(IL), .FL(FL)) u_xm  (.i_a(w_xhat_cur), .i_b(r_mg),       .o_p(w_xm));
    fx_mul_sat #(.IL(IL), .FL(FL)) u_sc  (.i_a(w_sc_a),     .i_b(w_sc_b),     .o_p(w_sc_p));

    always_comb begin
        w_acc_b64 = {{(64-AW){r_acc_b[AW-1]}}, r_acc_b};
        w_acc_g64 = {{(64-AW){r_acc_g[AW-1]}}, r_acc_g};
        w_recip64 = {32'd0, recip(int'(r_n), FL)};
        w_dout64  = {{(64-W){w_dout_cur[W-1]}}, w_dout_cur};
        w_inner64 = sat_q({{(64-W){r_mb[W-1]}}, r_mb} + {{(64-W){w_xm[W-1]}}, w_xm}, IL, FL);
        w_diff    = W'(sat_q(w_dout64 - w_inner64, IL, FL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_ACC;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_phase <= w_phase_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_idx_nx   = r_idx;
        case (r_state)
            ST_IDLE: if (input_ready) begin
                w_state_nx = ST_BUSY;
                w_idx_nx   = '0;
                // An empty batch has nothing to accumulate, so it enters SCALE directly.
                w_phase_nx = (w_n_in == '0) ? PH_SCALE : PH_ACC;
            end
            ST_BUSY: case (r_phase)
                PH_ACC: begin
                    if (w_last) begin
                        w_phase_nx = PH_SCALE;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
                PH_SCALE: begin
                    if (r_n == '0) w_state_nx = ST_DONE;
                    else           w_phase_nx = PH_DX;
                end
                PH_DX: begin
                    if (w_last) begin
                        w_state_nx = ST_DONE;
                        w_idx_nx   = '0;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
                default: w_phase_nx = PH_ACC;
            endcase
            ST_DONE: if (output_taken) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_n       <= '0;
            r_acc_b   <= '0;
            r_acc_g   <= '0;
            r_gamma   <= '0;
            r_inv_std <= '0;
            r_mb      <= '0;
            r_mg      <= '0;
            r_scale   <= '0;
            r_dbeta   <= '0;
            r_dgamma  <= '0;
            for (int unsigned i = 0; i < size; i++) begin
                r_dout[i] <= '0;
                r_xhat[i] <= '0;
                r_dx[i]   <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: if (input_ready) begin
                    for (int unsigned i = 0; i < size; i++) begin
                        r_dout[i] <= dout[i*W +: W];
                        r_xhat[i] <= xhat[i*W +: W];
                        r_dx[i]   <= '0;
                    end
                    r_gamma   <= gamma;
                    r_inv_std <= inv_std;
                    r_n       <= w_n_in;
                    r_acc_b   <= '0;
                    r_acc_g   <= '0;
                    r_dbeta   <= '0;
                    r_dgamma  <= '0;
                end
                ST_BUSY: case (r_phase)
                    PH_ACC: begin
                        r_acc_b <= r_acc_b + {{(AW-W){w_dout_cur[W-1]}}, w_dout_cur};
                        r_acc_g <= r_acc_g + {{(AW-W){w_prod_acc[W-1]}}, w_prod_acc};
                    end
                    PH_SCALE: begin
                        r_dbeta  <= W'(sat_q(w_acc_b64, IL, FL));
                        r_dgamma <= W'(sat_q(w_acc_g64, IL, FL));
                        r_mb     <= W'(sat_q((w_acc_b64 * w_recip64) >>> FL, IL, FL));
                        r_mg     <= W'(sat_q((w_acc_g64 * w_recip64) >>> FL, IL, FL));
                        r_scale  <= w_sc_p;
                    end
                    PH_DX: r_dx[r_idx] <= w_sc_p;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

    always_comb begin
        dx = '0;
        for (int unsigned i = 0; i < size; i++) dx[i*W +: W] = r_dx[i];
    end

    assign dbeta  = r_dbeta;
    assign dgamma = r_dgamma;
    assign state  = r_state;
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_batchnorm_backward.sv
// Scoreboard bench for batchnorm_backward: driver pushes model results, monitor checks on done.
module tb_batchnorm_backward;
    localparam int IL = 4, FL = 16, SIZE = 16, W = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic [SIZE*W-1:0]   dout, xhat, dx;
    logic signed [W-1:0] gamma, inv_std, dgamma, dbeta;
    logic [4:0]          num;
    logic                input_ready, output_taken;
    logic [1:0]          state;
    logic                done;

    always #5 clk = ~clk;

    batchnorm_backward #(.IL(IL), .FL(FL), .size(SIZE)) dut (
        .clk(clk), .reset(reset), .dout(dout), .xhat(xhat), .gamma(gamma), .inv_std(inv_std),
        .num(num), .input_ready(input_ready), .output_taken(output_taken), .dx(dx),
        .dgamma(dgamma), .dbeta(dbeta), .state(state), .done(done)
    );

    typedef struct {
        longint dx [SIZE];
        longint db;
        longint dg;
        int     n;
        int     acc_cyc;
    } exp_t;

    exp_t   q[$];
    exp_t   cur;
    exp_t   zero;
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    longint s_d [SIZE];
    longint s_x [SIZE];
    longint s_g, s_is;
    int     s_num;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint msat(longint v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    function automatic longint mfx(longint a, longint b);
        return msat((a * b) >>> FL);
    endfunction

    // Reference: the batch-norm backward formulas evaluated directly in wide integers.
    function automatic exp_t model();
        exp_t   e;
        longint ab, ag, r, mb, mg, sc;
        int     n;
        n  = (s_num > SIZE) ? SIZE : s_num;
        ab = 0;
        ag = 0;
        for (int i = 0; i < n; i++) begin
            ab += s_d[i];
            ag += mfx(s_d[i], s_x[i]);
        end
        e.db = msat(ab);
        e.dg = msat(ag);
        r  = (n == 0) ? 0 : 65536 / n;
        mb = msat((ab * r) >>> FL);
        mg = msat((ag * r) >>> FL);
        sc = mfx(s_g, s_is);
        for (int i = 0; i < SIZE; i++)
            e.dx[i] = (i < n) ? mfx(sc, msat(s_d[i] - msat(mb + mfx(s_x[i], mg)))) : 0;
        e.n = n;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic longint rq(longint range);
        return longint'($urandom_range(0, 32'(2 * range))) - range;
    endfunction

    function automatic longint dx_at(int i);
        logic signed [W-1:0] t;
        t = dx[i*W +: W];
        return longint'(t);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic compare_all(input exp_t e, input string tag);
        check({tag, "_dbeta"}, longint'(dbeta), e.db);
        check({tag, "_dgamma"}, longint'(dgamma), e.dg);
        for (int i = 0; i < SIZE; i++) check($sformatf("%s_dx%0d", tag, i), dx_at(i), e.dx[i]);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < SIZE; i++) begin
            dout[i*W +: W] = W'(s_d[i]);
            xhat[i*W +: W] = W'(s_x[i]);
        end
        gamma   = W'(s_g);
        inv_std = W'(s_is);
        num     = 5'(s_num);
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < SIZE; i++) begin
            dout[i*W +: W] = W'($urandom);
            xhat[i*W +: W] = W'($urandom);
        end
        gamma   = W'($urandom);
        inv_std = W'($urandom);
        num     = 5'($urandom);
    endtask

    task automatic fill_random(input longint range);
        for (int i = 0; i < SIZE; i++) begin
            s_d[i] = rq(range);
            s_x[i] = rq(range);
        end
        s_g  = rq(range);
        s_is = rq(range);
    endtask

    task automatic set_plan_vec();
        for (int i = 0; i < SIZE; i++) s_x[i] = 0;
        s_x[0] = -98304;
        s_x[1] = -32768;
        s_x[2] = 32768;
        s_x[3] = 98304;
    endtask

    task automatic run_txn(input int hold, input bit pulse, input bit both);
        exp_t e;
        int   k;
        @(negedge clk);
        apply_inputs();
        e = model();
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        scramble_inputs();
        check("busy_after_accept", longint'(state), 1);
        if (pulse) begin
            input_ready = 1'b1;
            @(negedge clk);
            input_ready = 1'b0;
        end
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", k);
            q.delete();
            return;
        end
        repeat (hold) @(negedge clk);
        output_taken = 1'b1;
        input_ready  = both;
        @(negedge clk);
        output_taken = 1'b0;
        input_ready  = 1'b0;
        check("idle_state", longint'(state), 0);
        check("idle_done", longint'(done), 0);
        check("idle_hold_dbeta", longint'(dbeta), e.db);
    endtask

    task automatic reset_in_dx();
        exp_t e;
        fill_random(131072);
        s_num = 8;
        @(negedge clk);
        apply_inputs();
        e = model();
        e.acc_cyc = cyc + 1;
        q.push_back(e);
        input_ready = 1'b1;
        @(negedge clk);
        input_ready = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_reset_busy", longint'(state), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_state", longint'(state), 0);
        check("abort_done", longint'(done), 0);
        compare_all(zero, "abort");
        q.delete(q.size() - 1);
    endtask

    initial begin : monitor
        bit prev_done;
        bit have_cur;
        prev_done = 1'b0;
        have_cur  = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    cur = q.pop_front();
                    have_cur = 1'b1;
                    // Edge count includes the accept edge as the first, so done appears 2n+1 edges later.
                    check("latency_edges", longint'(cyc - cur.acc_cyc), longint'(2 * cur.n + 1));
                    compare_all(cur, "result");
                end
            end else if (done && have_cur) begin
                check("hold_state", longint'(state), 2);
                compare_all(cur, "hold");
            end
            prev_done = done;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        reset = 1'b1;
        input_ready = 1'b0;
        output_taken = 1'b0;
        dout = '0;
        xhat = '0;
        gamma = '0;
        inv_std = '0;
        num = '0;
        repeat (3) @(negedge clk);
        check("rst_state", longint'(state), 0);
        check("rst_done", longint'(done), 0);
        compare_all(zero, "rst");
        reset = 1'b0;

        set_plan_vec();
        for (int i = 0; i < SIZE; i++) s_d[i] = 65536;
        s_g = 65536; s_is = 65536; s_num = 4;
        run_txn(20, 1'b1, 1'b0);

        set_plan_vec();
        for (int i = 0; i < SIZE; i++) s_d[i] = s_x[i];
        s_g = 131072; s_is = 32768; s_num = 4;
        run_txn(1, 1'b0, 1'b0);

        s_num = 0;
        run_txn(2, 1'b1, 1'b0);

        fill_random(131072);
        s_num = 16;
        run_txn(1, 1'b0, 1'b0);
        s_num = 20;
        run_txn(1, 1'b0, 1'b1);

        for (int i = 0; i < SIZE; i++) begin
            s_d[i] = 491520;
            s_x[i] = 0;
        end
        s_g = 65536; s_is = 65536; s_num = 16;
        run_txn(0, 1'b1, 1'b0);

        reset_in_dx();
        set_plan_vec();
        for (int i = 0; i < SIZE; i++) s_d[i] = s_x[i];
        s_g = 131072; s_is = 32768; s_num = 4;
        run_txn(1, 1'b0, 1'b0);

        repeat (25) begin
            fill_random(($urandom_range(0, 1) == 0) ? 131072 : 524287);
            s_num = int'($urandom_range(0, 20));
            run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", longint'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
